// File: rtl/encoder_16to4_pkg.sv
// Shared widths, state type and popcount helper for the 16-to-4 scanning encoder.
package encoder_pkg;

  localparam int IN_W   = 16;
  localparam int CODE_W = 4;
  localparam int CNT_W  = 5;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < IN_W; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/encoder_16to4_if.sv
// Input vector handshake and output code stream of the scanning encoder.
interface encoder_16to4_if;
  import encoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   decoded;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] select;
  logic              last;
  logic [CNT_W-1:0]  count;
  logic              zero;

  modport master (
    output in_valid, decoded, out_ready,
    input  in_ready, out_valid, select, last, count, zero
  );

  modport slave (
    input  in_valid, decoded, out_ready,
    output in_ready, out_valid, select, last, count, zero
  );

endinterface

// File: rtl/encoder_16to4_bit_find.sv
// Combinational priority finder: index of the first set bit in scan order,
// plus flags for "any bit set" and "exactly one bit set".
module bit_find
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [IN_W-1:0]   vec,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic              single
);

  // The last matching assignment wins, so the loop direction sets the priority.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - IN_W'(1))) == '0);

endmodule

// File: rtl/encoder_16to4.sv
// Accepts a multi-hot vector and streams out the index of each set bit,
// one code per output handshake, in the configured scan order.
module encoder_16to4
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst,
  encoder_16to4_if.slave bus
);

  state_t            state;
  logic [IN_W-1:0]   pending;
  logic [IN_W-1:0]   sel_mask;
  logic [IN_W-1:0]   remaining;
  logic [IN_W-1:0]   find_vec;
  logic [CODE_W-1:0] select_q;
  logic [CODE_W-1:0] find_idx;
  logic              find_any;
  logic              find_single;
  logic              last_q;
  logic              zero_q;
  logic [CNT_W-1:0]  count_q;
  logic              accept;

  // One finder serves both cases: the incoming vector while idle, and the
  // pending bits left after the current code while emitting.
  always_comb begin
    sel_mask           = '0;
    sel_mask[select_q] = 1'b1;
    remaining          = pending & ~sel_mask;
    find_vec           = (state == IDLE) ? bus.decoded : remaining;
  end

  bit_find #(.LSB_FIRST(LSB_FIRST)) u_find (
    .vec    (find_vec),
    .idx    (find_idx),
    .any    (find_any),
    .single (find_single)
  );

  assign accept = bus.in_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      select_q <= '0;
      last_q   <= 1'b0;
      count_q  <= '0;
      zero_q   <= 1'b0;
    end else begin
      zero_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            count_q <= popcount(bus.decoded);
            pending <= bus.decoded;
            if (find_any) begin
              select_q <= find_idx;
              last_q   <= find_single;
              state    <= EMIT;
            end else begin
              zero_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            pending <= remaining;
            if (last_q) begin
              last_q <= 1'b0;
              state  <= IDLE;
            end else begin
              select_q <= find_idx;
              last_q   <= find_single;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == EMIT);
  assign bus.select    = select_q;
  assign bus.last      = last_q;
  assign bus.count     = count_q;
  assign bus.zero      = zero_q;

endmodule

// File: doc/encoder_16to4.md
ENCODER_16TO4 -- requirements
Module: encoder_16to4

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1, scan order: 1 = lowest set bit first, 0 = highest set bit first.
REQ-002 The block SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, which is high when a vector is offered on decoded.
REQ-005 The block SHALL have port in_ready, output, 1, which is high when the block can accept a vector.
REQ-006 The block SHALL have port decoded, input, 16, a multi-hot vector; bit i set means code i is pending.
REQ-007 The block SHALL have port out_valid, output, 1, which is high when select holds a valid code.
REQ-008 The block SHALL have port out_ready, input, 1, which is high when the consumer takes the current code.
REQ-009 The block SHALL have port select, output, 4, the index of the current set bit.
REQ-010 The block SHALL have port last, output, 1, which is high when the current code is the final code of the vector.
REQ-011 The block SHALL have port count, output, 5, the popcount of the last accepted vector, held until the next accept.
REQ-012 The block SHALL have port zero, output, 1, a one-cycle pulse after an all-zero vector is accepted.

Function
REQ-013 The block SHALL implement two states, IDLE and EMIT, with in_ready = 1 only in IDLE and accept = in_valid & in_ready.
REQ-014 On accept of a non-zero vector, the block SHALL latch it into a pending register, set count = popcount, and enter EMIT, with out_valid asserted the next cycle (1-cycle latency).
REQ-015 On accept of a zero vector, the block SHALL stay in IDLE, set count = 0, pulse zero for exactly the next cycle, and never assert out_valid.
REQ-016 In EMIT, the block SHALL drive out_valid = 1 and select = index of the lowest (LSB_FIRST=1) or highest (LSB_FIRST=0) set pending bit; last = 1 iff exactly one pending bit remains.
REQ-017 While out_valid & !out_ready, the block SHALL hold select, last and the pending register stable.
REQ-018 On each out_valid & out_ready, the block SHALL clear the selected pending bit; if last, it returns to IDLE (out_valid = 0, in_ready = 1 next cycle); otherwise it presents the next code the next cycle.
REQ-019 With out_ready held high, the block SHALL emit one code per cycle: a k-bit vector occupies k EMIT cycles after the accept cycle.
REQ-020 The block SHALL ignore decoded and in_valid during EMIT; no accept is permitted in the same cycle as the final output handshake.
REQ-021 For vector 16'hFFFF, the block SHALL emit 16 codes and report count = 16; the 5-bit count width is mandatory.
REQ-022 For a one-hot vector, the block SHALL emit exactly one beat, with last = 1 and select = the bit index.

Reset
REQ-023 With rst = 1 at a clock edge, the block SHALL go to state IDLE with pending = 0, out_valid = 0, select = 0, last = 0, count = 0, zero = 0, and in_ready = 1 from the first cycle after rst deasserts.
REQ-024 If rst is asserted during EMIT, the block SHALL abort the remaining codes, with out_valid = 0 from the next cycle.
REQ-025 If rst and in_valid are both asserted at the same edge, the block SHALL give rst priority and accept no vector.

Structure
REQ-026 Package encoder_pkg SHALL hold IN_W = 16, CODE_W = 4, CNT_W = 5, and the IDLE/EMIT state enum type.
REQ-027 The block SHALL use one combinational sub-module, bit_find: inputs a 16-bit vector and LSB_FIRST; outputs a 4-bit index, an any flag, and a single flag (exactly one bit set).
REQ-028 The block SHALL drive select, last, out_valid and zero from registered state only; popcount is computed at accept time, not in the output path.

Verification
REQ-029 The bench SHALL cover: reset, then decoded=16'h0001 for one cycle with out_ready=1 -> one beat select=0, last=1, count=1; in_ready=1 the cycle after.
REQ-030 The bench SHALL cover: decoded=16'h8421, LSB_FIRST=1, out_ready=1 -> select 0,5,10,15 on consecutive cycles, last only with 15, count=4.
REQ-031 The bench SHALL cover: decoded=16'hFFFF with out_ready alternating 1/0 -> codes 0..15 in order, each held stable through stalls, count=16, in_ready=0 throughout.
REQ-032 The bench SHALL cover: decoded=16'h0000 accepted -> zero=1 for one cycle, count=0, out_valid never 1, in_ready stays 1.
REQ-033 The bench SHALL cover: decoded=16'h00F0, rst after the 2nd handshake -> out_valid=0 next cycle with all outputs at reset values; a subsequent 16'h0002 yields select=1, last=1.
REQ-034 The bench SHALL cover: LSB_FIRST=0, decoded=16'h0301 -> select 9, 8, 0, with last only on 0, count=3.
